// File: rtl/demux_registrado.sv
// -----------------------------------------------------------------------------
// demux_registrado
//
// Registered 1-to-2 demultiplexer with valid/ready handshakes. Each upstream
// word is routed by `sel` into one of two single-entry output registers. A
// channel can take a new word when it is empty or when its consumer is
// draining it in the same cycle, so a channel with a ready consumer sustains
// one word per cycle. A stalled channel never blocks traffic to the other
// channel. Each channel also counts the words it has accepted since reset,
// modulo 256.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   reset            : synchronous active-high reset
//   entrada          : upstream data word (ANCHO bits)
//   entrada_valida   : upstream word present
//   sel              : destination channel for the current word (0 or 1)
//   entrada_lista    : the block accepts the word this cycle (combinational)
//   salida_k         : channel k registered data (k = 0, 1)
//   salida_k_valida  : channel k holds a word
//   salida_k_lista   : channel k consumer takes the word this cycle
//   cuenta_k         : words accepted into channel k since reset (wraps)
// -----------------------------------------------------------------------------
module demux_registrado #(
  parameter int ANCHO = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] entrada,
  input  logic             entrada_valida,
  input  logic             sel,
  output logic             entrada_lista,
  output logic [ANCHO-1:0] salida_0,
  output logic             salida_0_valida,
  input  logic             salida_0_lista,
  output logic [ANCHO-1:0] salida_1,
  output logic             salida_1_valida,
  input  logic             salida_1_lista,
  output logic [7:0]       cuenta_0,
  output logic [7:0]       cuenta_1
);

  // Per-channel state, indexed by channel number.
  logic [ANCHO-1:0] datos_reg  [2];
  logic             valida_reg [2];
  logic [7:0]       cuenta_reg [2];

  // Per-channel handshake views.
  logic [1:0] lista_ch;
  logic [1:0] libre;
  logic [1:0] acepta;

  assign lista_ch = {salida_1_lista, salida_0_lista};

  // Ready only depends on the addressed channel and reset, never on
  // entrada_valida, so upstream may look at it before presenting a word.
  assign entrada_lista = ~reset & (sel ? libre[1] : libre[0]);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_canal
      localparam logic CANAL = 1'(gi);

      // A channel is free when empty or when its word leaves this cycle;
      // the latter lets accept and drain overlap without a bubble.
      assign libre[gi]  = ~valida_reg[gi] | lista_ch[gi];
      assign acepta[gi] = entrada_valida & entrada_lista & (sel == CANAL);

      always_ff @(posedge clk) begin
        if (reset) begin
          datos_reg[gi]  <= '0;
          valida_reg[gi] <= 1'b0;
          cuenta_reg[gi] <= '0;
        end else if (acepta[gi]) begin
          // New word wins over a simultaneous drain: the register is
          // refilled and the valid flag stays high.
          datos_reg[gi]  <= entrada;
          valida_reg[gi] <= 1'b1;
          cuenta_reg[gi] <= cuenta_reg[gi] + 8'd1;
        end else if (lista_ch[gi]) begin
          // Drain; data keeps its last value. With valid already low
          // this is a no-op.
          valida_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign salida_0        = datos_reg[0];
  assign salida_0_valida = valida_reg[0];
  assign cuenta_0        = cuenta_reg[0];
  assign salida_1        = datos_reg[1];
  assign salida_1_valida = valida_reg[1];
  assign cuenta_1        = cuenta_reg[1];

endmodule

// File: tb/tb_demux_registrado.sv
// -----------------------------------------------------------------------------
// tb_demux_registrado
//
// Directed self-checking bench for demux_registrado. Inputs are driven 1 ns
// after the rising edge and outputs are sampled there too, or 1 ns after a
// drive change for the combinational ready.
// -----------------------------------------------------------------------------
module tb_demux_registrado;

  localparam int ANCHO = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic [ANCHO-1:0] entrada;
  logic             entrada_valida;
  logic             sel;
  logic             entrada_lista;
  logic [ANCHO-1:0] salida_0;
  logic             salida_0_valida;
  logic             salida_0_lista;
  logic [ANCHO-1:0] salida_1;
  logic             salida_1_valida;
  logic             salida_1_lista;
  logic [7:0]       cuenta_0;
  logic [7:0]       cuenta_1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_registrado #(.ANCHO(ANCHO)) dut (
    .clk             (clk),
    .reset           (reset),
    .entrada         (entrada),
    .entrada_valida  (entrada_valida),
    .sel             (sel),
    .entrada_lista   (entrada_lista),
    .salida_0        (salida_0),
    .salida_0_valida (salida_0_valida),
    .salida_0_lista  (salida_0_lista),
    .salida_1        (salida_1),
    .salida_1_valida (salida_1_valida),
    .salida_1_lista  (salida_1_lista),
    .cuenta_0        (cuenta_0),
    .cuenta_1        (cuenta_1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    entrada_valida = 1'b0;
    entrada = '0;
    sel = 1'b0;
    salida_0_lista = 1'b0;
    salida_1_lista = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    entrada = 11'h7FF;
    entrada_valida = 1'b1;
    sel = 1'b0;
    salida_0_lista = 1'b1;
    salida_1_lista = 1'b1;
    step();
    step();
    checks++; if (entrada_lista !== 1'b0) begin failures++; $display("FAIL reset_lista got=%b exp=0", entrada_lista); end
    checks++; if (salida_0_valida !== 1'b0 || salida_1_valida !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b%b exp=00", salida_1_valida, salida_0_valida); end
    checks++; if (salida_0 !== 11'h000 || salida_1 !== 11'h000) begin failures++; $display("FAIL reset_data got=%h/%h exp=000/000", salida_0, salida_1); end
    checks++; if (cuenta_0 !== 8'd0 || cuenta_1 !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0", cuenta_0, cuenta_1); end
    $display("test_reset: outputs cleared, no accept during reset");
  endtask

  // Route one word to channel 0 on the first edge after reset, then drain it.
  task automatic test_basic_route();
    apply_reset();
    entrada = 11'h155;
    sel = 1'b0;
    entrada_valida = 1'b1;
    salida_0_lista = 1'b1;
    #1;
    checks++; if (entrada_lista !== 1'b1) begin failures++; $display("FAIL basic_lista got=%b exp=1", entrada_lista); end
    step();
    entrada_valida = 1'b0;
    checks++; if (salida_0 !== 11'h155) begin failures++; $display("FAIL basic_data got=%h exp=155", salida_0); end
    checks++; if (salida_0_valida !== 1'b1) begin failures++; $display("FAIL basic_v0 got=%b exp=1", salida_0_valida); end
    checks++; if (salida_1_valida !== 1'b0) begin failures++; $display("FAIL basic_v1 got=%b exp=0", salida_1_valida); end
    checks++; if (cuenta_0 !== 8'd1 || cuenta_1 !== 8'd0) begin failures++; $display("FAIL basic_count got=%0d/%0d exp=1/0", cuenta_0, cuenta_1); end
    step();
    checks++; if (salida_0_valida !== 1'b0) begin failures++; $display("FAIL basic_drain_v0 got=%b exp=0", salida_0_valida); end
    checks++; if (salida_0 !== 11'h155) begin failures++; $display("FAIL basic_drain_hold got=%h exp=155", salida_0); end
    // Ready asserted on an empty channel must change nothing.
    step();
    checks++; if (salida_0_valida !== 1'b0 || cuenta_0 !== 8'd1) begin failures++; $display("FAIL basic_idle got=v%b c%0d exp=v0 c1", salida_0_valida, cuenta_0); end
    $display("test_basic_route: 0x155 -> channel 0");
  endtask

  // Channel 1 stalls on 0x001; 0x002 waits, then refills the draining slot.
  task automatic test_backpressure();
    apply_reset();
    salida_1_lista = 1'b0;
    entrada = 11'h001;
    sel = 1'b1;
    entrada_valida = 1'b1;
    #1;
    checks++; if (entrada_lista !== 1'b1) begin failures++; $display("FAIL bp_first_lista got=%b exp=1", entrada_lista); end
    step();
    entrada = 11'h002;
    #1;
    checks++; if (entrada_lista !== 1'b0) begin failures++; $display("FAIL bp_stall_lista got=%b exp=0", entrada_lista); end
    step();
    checks++; if (salida_1 !== 11'h001 || salida_1_valida !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h v%b exp=001 v1", salida_1, salida_1_valida); end
    checks++; if (cuenta_1 !== 8'd1) begin failures++; $display("FAIL bp_count_stall got=%0d exp=1", cuenta_1); end
    salida_1_lista = 1'b1;
    #1;
    checks++; if (entrada_lista !== 1'b1) begin failures++; $display("FAIL bp_release_lista got=%b exp=1", entrada_lista); end
    step();
    entrada_valida = 1'b0;
    salida_1_lista = 1'b0;
    checks++; if (salida_1 !== 11'h002 || salida_1_valida !== 1'b1) begin failures++; $display("FAIL bp_second got=%h v%b exp=002 v1", salida_1, salida_1_valida); end
    checks++; if (cuenta_1 !== 8'd2 || cuenta_0 !== 8'd0) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=0/2", cuenta_0, cuenta_1); end
    $display("test_backpressure: 0x001 then 0x002 on channel 1");
  endtask

  // Channel 0 stalled does not block channel 1; both then drain together.
  task automatic test_isolation();
    apply_reset();
    entrada = 11'h3FF;
    sel = 1'b0;
    entrada_valida = 1'b1;
    step();
    entrada = 11'h0AA;
    sel = 1'b1;
    salida_1_lista = 1'b1;
    #1;
    checks++; if (entrada_lista !== 1'b1) begin failures++; $display("FAIL iso_lista got=%b exp=1", entrada_lista); end
    step();
    entrada_valida = 1'b0;
    salida_1_lista = 1'b0;
    checks++; if (salida_1 !== 11'h0AA || salida_1_valida !== 1'b1) begin failures++; $display("FAIL iso_ch1 got=%h v%b exp=0aa v1", salida_1, salida_1_valida); end
    checks++; if (salida_0 !== 11'h3FF || salida_0_valida !== 1'b1) begin failures++; $display("FAIL iso_ch0 got=%h v%b exp=3ff v1", salida_0, salida_0_valida); end
    step();
    checks++; if (salida_0 !== 11'h3FF || salida_1 !== 11'h0AA) begin failures++; $display("FAIL iso_stable got=%h/%h exp=3ff/0aa", salida_0, salida_1); end
    salida_0_lista = 1'b1;
    salida_1_lista = 1'b1;
    step();
    checks++; if (salida_0_valida !== 1'b0 || salida_1_valida !== 1'b0) begin failures++; $display("FAIL iso_drain_both got=%b%b exp=00", salida_1_valida, salida_0_valida); end
    $display("test_isolation: 0x0AA passes stalled channel 0");
  endtask

  // Six words alternating channels at one per cycle.
  task automatic test_back_to_back();
    logic [ANCHO-1:0] palabras [6];
    logic [ANCHO-1:0] ultimo [2];
    palabras = '{11'h010, 11'h121, 11'h232, 11'h343, 11'h454, 11'h565};
    apply_reset();
    salida_0_lista = 1'b1;
    salida_1_lista = 1'b1;
    ultimo[0] = '0;
    ultimo[1] = '0;
    for (int i = 0; i < 6; i++) begin
      entrada = palabras[i];
      sel = 1'(i % 2);
      entrada_valida = 1'b1;
      #1;
      checks++; if (entrada_lista !== 1'b1) begin failures++; $display("FAIL b2b_lista[%0d] got=%b exp=1", i, entrada_lista); end
      step();
      ultimo[i % 2] = palabras[i];
      checks++; if (salida_0 !== ultimo[0] || salida_1 !== ultimo[1]) begin failures++; $display("FAIL b2b_data[%0d] got=%h/%h exp=%h/%h", i, salida_0, salida_1, ultimo[0], ultimo[1]); end
    end
    entrada_valida = 1'b0;
    checks++; if (cuenta_0 !== 8'd3 || cuenta_1 !== 8'd3) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=3/3", cuenta_0, cuenta_1); end
    $display("test_back_to_back: 6 words, 3 per channel");
  endtask

  task automatic test_wrap();
    apply_reset();
    salida_0_lista = 1'b1;
    sel = 1'b0;
    entrada_valida = 1'b1;
    for (int i = 0; i < 255; i++) begin
      entrada = 11'(i);
      step();
    end
    checks++; if (cuenta_0 !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", cuenta_0); end
    entrada = 11'h4FF;
    step();
    entrada_valida = 1'b0;
    checks++; if (cuenta_0 !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d exp=0", cuenta_0); end
    checks++; if (salida_0 !== 11'h4FF || cuenta_1 !== 8'd0) begin failures++; $display("FAIL wrap_last got=%h c1=%0d exp=4ff c1=0", salida_0, cuenta_1); end
    $display("test_wrap: 256 accepts into channel 0");
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    entrada = 11'h3FF;
    sel = 1'b0;
    entrada_valida = 1'b1;
    step();
    entrada = 11'h0AA;
    sel = 1'b1;
    step();
    checks++; if (salida_0_valida !== 1'b1 || salida_1_valida !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b%b exp=11", salida_1_valida, salida_0_valida); end
    reset = 1'b1;
    sel = 1'b0;
    salida_0_lista = 1'b1;
    #1;
    checks++; if (entrada_lista !== 1'b0) begin failures++; $display("FAIL mid_lista got=%b exp=0", entrada_lista); end
    step();
    reset = 1'b0;
    entrada_valida = 1'b0;
    salida_0_lista = 1'b0;
    checks++; if (salida_0 !== 11'h000 || salida_1 !== 11'h000) begin failures++; $display("FAIL mid_data got=%h/%h exp=000/000", salida_0, salida_1); end
    checks++; if (cuenta_0 !== 8'd0 || cuenta_1 !== 8'd0) begin failures++; $display("FAIL mid_count got=%0d/%0d exp=0/0", cuenta_0, cuenta_1); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (salida_0_valida !== 1'b0 || salida_1_valida !== 1'b0) begin failures++; $display("FAIL mid_no_pulse[%0d] got=%b%b exp=00", i, salida_1_valida, salida_0_valida); end
      step();
    end
    $display("test_reset_mid_stall: held words discarded");
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_wrap();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_registrado.md
DEMUX_REGISTRADO -- requirements
Module: demux_registrado

Interface
REQ-001 The block SHALL have parameter ANCHO, default 11, giving the data word width in bits.
REQ-002 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port entrada, input, ANCHO: upstream data word.
REQ-005 Port entrada_valida, input, 1: upstream word present.
REQ-006 Port sel, input, 1: destination channel for the current word (0 -> channel 0, 1 -> channel 1).
REQ-007 Port entrada_lista, output, 1: block accepts the word this cycle.
REQ-008 Port salida_0, output, ANCHO: channel 0 registered data.
REQ-009 Port salida_0_valida, output, 1: channel 0 holds a word.
REQ-010 Port salida_0_lista, input, 1: channel 0 consumer takes the word this cycle.
REQ-011 Ports salida_1, salida_1_valida, salida_1_lista SHALL mirror REQ-008..REQ-010 for channel 1.
REQ-012 Port cuenta_0, output, 8: words accepted into channel 0 since reset.
REQ-013 Port cuenta_1, output, 8: words accepted into channel 1 since reset.

Function
REQ-014 Each channel SHALL hold exactly one registered word (data register plus valid flag).
REQ-015 Channel k SHALL be "free" when salida_k_valida=0 or salida_k_lista=1.
REQ-016 entrada_lista SHALL be combinational: 1 iff reset=0 and the channel addressed by sel is free; entrada_lista SHALL NOT depend on entrada_valida.
REQ-017 Accept SHALL occur when entrada_valida=1 and entrada_lista=1; on that edge entrada SHALL be loaded into salida_sel and salida_sel_valida set to 1 (latency: one cycle from accept to output).
REQ-018 sel SHALL be significant only when entrada_valida=1; upstream SHALL hold entrada and sel stable while entrada_valida=1 and entrada_lista=0.
REQ-019 Drain: when salida_k_valida=1, salida_k_lista=1 and no accept targets channel k, salida_k_valida SHALL clear on the next edge; salida_k SHALL keep its last value.
REQ-020 Simultaneous drain and accept on the same channel SHALL leave salida_k_valida=1 and salida_k loaded with the new word (no bubble).
REQ-021 A stalled channel (valid=1, lista=0) SHALL NOT block words addressed to the other channel.
REQ-022 salida_k and salida_k_valida SHALL be stable while salida_k_valida=1 and salida_k_lista=0.
REQ-023 Both channels SHALL drain independently in the same cycle.
REQ-024 Word order within a channel SHALL equal acceptance order; no word SHALL be dropped or duplicated.
REQ-025 cuenta_k SHALL increment by 1 on each accept into channel k, wrapping 255 -> 0; no change otherwise.
REQ-026 salida_k_lista asserted while salida_k_valida=0 SHALL have no effect.

Reset
REQ-027 With reset=1 at an edge: salida_0, salida_1 SHALL become 0; both valid flags 0; cuenta_0, cuenta_1 0.
REQ-028 entrada_lista SHALL be 0 while reset=1; no accept SHALL occur during reset.
REQ-029 Reset mid-operation SHALL discard held words without any salida_k_valida pulse after the reset edge.
REQ-030 First accept SHALL be possible on the first edge with reset=0.

Verification
REQ-031 Basic route: reset, then entrada=0x155, sel=0, valid=1 one cycle, salida_0_lista=1 -> next cycle salida_0=0x155, salida_0_valida=1, salida_1_valida=0, cuenta_0=1.
REQ-032 Back-pressure: salida_1_lista=0, send 0x001 then 0x002 to sel=1 -> 0x001 held, entrada_lista=0 for second word until salida_1_lista=1, then 0x002 appears one cycle later; cuenta_1=2.
REQ-033 Isolation: channel 0 stalled with 0x3FF held, send 0x0AA sel=1 -> accepted immediately, salida_1=0x0AA next cycle, salida_0 still 0x3FF.
REQ-034 Full throughput: both lista=1, 6 words alternating sel -> one accept per cycle, no bubbles, per-channel order preserved, cuenta_0=3, cuenta_1=3.
REQ-035 Wrap: 256 accepts into channel 0 -> cuenta_0=0 after the 256th, 255 immediately before.
REQ-036 Reset mid-stall: both channels valid and stalled, assert reset one cycle -> all outputs 0, entrada_lista=0 during reset, no valid pulse afterwards.
